// File: rtl/sr_chain_tester_if.sv
// Control and chain signals between the shift-register BIST sequencer and its surroundings.
// The master side drives start/abort/pattern and the chain output; the sequencer is the slave.
interface sr_chain_tester_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic             sr_out;
  logic             sr_in;
  logic             sr_clk_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_count;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output start, abort, pattern, sr_out,
    input  sr_in, sr_clk_en, busy, done, pass, err_count, first_err_idx
  );

  modport slave (
    input  start, abort, pattern, sr_out,
    output sr_in, sr_clk_en, busy, done, pass, err_count, first_err_idx
  );
endinterface

// File: rtl/sr_chain_tester.sv
// BIST sequencer for a latch-based shift-register chain: flush, load a repeating
// pattern, then drain and compare bit-by-bit, reporting error count and first failing index.
module sr_chain_tester #(
  parameter int LATENCY = 128,
  parameter int PAT_W   = 8,
  parameter int CNT_W   = $clog2(2*LATENCY+1)
) (
  input logic            clk,
  input logic            rst,
  sr_chain_tester_if.slave bus
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CHK_BASE = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] IDX_NONE = '1;
  localparam logic [IDX_W-1:0] PAT_LAST = IDX_W'(PAT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             sr_in_q, sr_in_d;
  logic             clk_en_q, clk_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [CNT_W-1:0] first_q, first_d;

  logic             cmp_en;
  logic             exp_bit;
  logic             mismatch;
  logic             phase_end;
  logic [CNT_W-1:0] cmp_idx;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [IDX_W-1:0] pat_idx_next(input logic [IDX_W-1:0] v);
    return (v == PAT_LAST) ? '0 : v + 1'b1;
  endfunction

  // Compare stage: LOAD expects the flushed zeros, CHECK expects the pattern stream back.
  always_comb begin
    cmp_en    = (state_q == S_LOAD) || (state_q == S_CHECK);
    exp_bit   = (state_q == S_CHECK) ? pat_q[idx_q] : 1'b0;
    cmp_idx   = (state_q == S_CHECK) ? CHK_BASE + cnt_q : cnt_q;
    mismatch  = cmp_en && (bus.sr_out != exp_bit);
    phase_end = (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;

    if (mismatch) begin
      err_d = sat_inc8(err_q);
      // err_count saturates but never returns to zero, so zero marks "no mismatch yet".
      if (err_q == 8'd0) first_d = cmp_idx;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = S_FLUSH;
          pat_d   = bus.pattern;
          err_d   = '0;
          pass_d  = 1'b0;
          first_d = IDX_NONE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_FLUSH, S_LOAD, S_CHECK: begin
        if (phase_end) begin
          cnt_d = '0;
          idx_d = '0;
          case (state_q)
            S_FLUSH: state_d = S_LOAD;
            S_LOAD:  state_d = S_CHECK;
            default: begin
              state_d = S_DONE;
              pass_d  = (err_d == 8'd0);
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
          idx_d = pat_idx_next(idx_q);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      err_d   = err_q;
      first_d = first_q;
      pass_d  = 1'b0;
    end

    // Outputs are registered, so they follow the state being entered.
    clk_en_d = (state_d == S_FLUSH) || (state_d == S_LOAD) || (state_d == S_CHECK);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    sr_in_d  = (state_d == S_LOAD) && pat_q[idx_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sr_in_q  <= 1'b0;
      clk_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      first_q  <= IDX_NONE;
    end else begin
      state_q  <= state_d;
      sr_in_q  <= sr_in_d;
      clk_en_q <= clk_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

  // Phase counters and captured pattern are only meaningful once a test is running.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    idx_q <= idx_d;
    pat_q <= pat_d;
  end

  assign bus.sr_in         = sr_in_q;
  assign bus.sr_clk_en     = clk_en_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;

endmodule

// File: doc/sr_chain_tester.md
# sr_chain_tester

Built-in self-test sequencer for the latch-based shift-register chain. It flushes the chain, streams a repeating pattern into it, then drains it while comparing the chain output bit-by-bit against the expected stream. It gates the chain's shift clock and reports pass/fail, error count and first failing index to the top-level I/O.

## Interface

**Parameters**
- `LATENCY`, default 128: chain delay in enabled shift cycles. Must be ≥1.
- `PAT_W`, default 8: pattern width in bits. Must be ≥1.
- `CNT_W`, default `$clog2(2*LATENCY+1)`: width of the phase counter and of `first_err_idx`.

**Ports**
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a test; sampled only in IDLE.
- `abort`  in  1  synchronous abort; overrides `start`.
- `pattern`  in  PAT_W  test pattern; captured when `start` is accepted.
- `sr_out`  in  1  chain output; sampled every cycle.
- `sr_in`  out  1  chain serial input.
- `sr_clk_en`  out  1  shift-clock gate enable to the chain.
- `busy`  out  1  high in FLUSH, LOAD, CHECK and DONE.
- `done`  out  1  one-cycle pulse at test end.
- `pass`  out  1  high when `err_count==0` after the last completed test.
- `err_count`  out  8  saturating mismatch count.
- `first_err_idx`  out  CNT_W  index of the first mismatch. All ones if there was no mismatch.

## Operation

- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values: `sr_in`=0, `sr_clk_en`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=all ones, state=IDLE.
- Chain model: `sr_out` sampled at the end of cycle c reflects `sr_in` driven in the enabled cycle c−LATENCY.
- States and behaviour:
  - **IDLE:** `sr_clk_en`=0, `sr_in`=0.
    - `start`=1 and `abort`=0: capture `pattern`; clear `err_count`, `pass` and `first_err_idx` (all ones); go to FLUSH.
  - **FLUSH** (LATENCY cycles): `sr_clk_en`=1, `sr_in`=0, no compare.
  - **LOAD** (LATENCY cycles): `sr_clk_en`=1, `sr_in`=pattern[i mod PAT_W], where i = cycle index within the phase starting at 0, LSB first. Compare `sr_out` against expected 0.
  - **CHECK** (LATENCY cycles): `sr_clk_en`=1, `sr_in`=0. Compare `sr_out` against pattern[j mod PAT_W], where j = cycle index within CHECK.
  - **DONE** (1 cycle): `sr_clk_en`=0, `done`=1, `pass`=(`err_count`==0). Next state IDLE.
- Modulo index: kept in a separate PAT_W-range counter that resets at each phase start. No divider.
- Compare index: LOAD samples use index i (0..LATENCY−1); CHECK samples use LATENCY+j.
- On every mismatch:
  - `err_count` increments, saturating at 255.
  - If this is the first mismatch of the test, `first_err_idx` takes the compare index.
- Results (`pass`, `err_count`, `first_err_idx`) hold from DONE until the next accepted `start`.
- `start` is ignored in every state except IDLE, including DONE.
- `abort`=1 in any non-IDLE state:
  - Next cycle: IDLE, `sr_clk_en`=0, `sr_in`=0, `busy`=0.
  - No `done` pulse. `pass`=0. `err_count` and `first_err_idx` keep their partial values.
- `rst` mid-test: behaves as the reset values above. No `done`.

## Timing

- `start` accepted at edge 0:
  - FLUSH occupies cycles 1..L.
  - LOAD occupies cycles L+1..2L.
  - CHECK occupies cycles 2L+1..3L.
  - `done`=1 in cycle 3L+1.
  - `busy` falls in cycle 3L+2.
- Throughput: the earliest next accepted `start` is sampled at the end of cycle 3L+2, in IDLE.
- Shift enable: `sr_clk_en` is high for exactly 3·LATENCY consecutive cycles per completed test.
- Last compare: the final CHECK sample (end of cycle 3L) is included in the values visible while `done`=1.
- `abort` sampled at the end of cycle c: outputs show IDLE values in cycle c+1.

## Test plan

Default bench: LATENCY=8, PAT_W=8, and a behavioural chain modelled as an 8-deep enabled delay line (CNT_W=5).

1. **Reset:** hold `rst` for 2 cycles with `start`=1 -> all outputs at reset values, `first_err_idx`=5'h1F, no FLUSH entered.
2. **Ideal chain:** `pattern`=8'hA5, `start` pulse -> `sr_clk_en` high for 24 cycles; `done` in cycle 25; `pass`=1, `err_count`=0, `first_err_idx`=5'h1F.
3. **Stuck-at-1 chain:** `pattern`=8'hA5 -> 8 LOAD errors + 4 CHECK errors; `err_count`=12, `first_err_idx`=0, `pass`=0.
4. **Off-by-one chain:** model latency 9, `pattern`=8'hFF -> single mismatch at the first CHECK sample; `err_count`=1, `first_err_idx`=8.
5. **Abort and ignored start:**
   - `abort` in LOAD cycle 3 -> next cycle `busy`=0, `sr_clk_en`=0, no `done`, `pass`=0.
   - A subsequent `start` runs a full test to completion.
   - `start` pulses during `busy` cause no restart.
6. **Saturation:** LATENCY=200, stuck-at-1 chain, `pattern`=8'h00 -> 400 mismatches; `err_count`=255, `first_err_idx`=0, `done` in cycle 601.
